// File: rtl/fetch_unit_if.sv
// Fetch unit bus: ROM port plus consumer-side instruction/redirect handshake.
interface fetch_unit_if #(
  parameter int unsigned PC_W   = 11,
  parameter int unsigned ROM_AW = 8,
  parameter int unsigned CNT_W  = 32
);
  logic              stall;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic [ROM_AW-1:0] rom_addr;
  logic [31:0]       rom_q;
  logic [31:0]       instr;
  logic [PC_W-1:0]   instr_pc;
  logic              instr_valid;
  logic [PC_W-1:0]   pc_plus4;
  logic              halted;
  logic [PC_W-1:0]   halt_pc;
  logic [CNT_W-1:0]  retired;

  modport master (
    input  stall, redirect, redirect_pc, rom_q,
    output rom_addr, instr, instr_pc, instr_valid, pc_plus4, halted, halt_pc, retired
  );

  modport slave (
    output stall, redirect, redirect_pc, rom_q,
    input  rom_addr, instr, instr_pc, instr_valid, pc_plus4, halted, halt_pc, retired
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: fetch PC, one-deep ROM request tracker,
// zero-bubble redirect, stall, illegal-opcode halt and retired counter.
module fetch_unit #(
  parameter int unsigned PC_W     = 11,
  parameter int unsigned ROM_AW   = 8,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned EXT_OPS  = 0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic        CLOCK_50,
  input  logic        rst_n,
  fetch_unit_if.master bus
);

  localparam logic [PC_W-1:0] RST_PC    = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] PC_STEP   = PC_W'(4);
  localparam logic [PC_W-1:0] WORD_MASK = ~PC_W'(3);

  localparam logic RUN  = 1'b0;
  localparam logic HALT = 1'b1;

  logic              state;
  logic              halted;
  logic [PC_W-1:0]   fpc;
  logic [PC_W-1:0]   req_pc;
  logic              req_valid;
  logic [PC_W-1:0]   halt_pc_q;
  logic [CNT_W-1:0]  retired_q;
  logic [PC_W-1:0]   tgt_pc;
  logic [PC_W-1:0]   sel_pc;
  logic              illegal;
  logic              instr_valid;
  logic              accept;
  logic              unused_sel;

  assign halted      = (state == HALT);
  assign tgt_pc      = bus.redirect_pc & WORD_MASK;
  assign instr_valid = req_valid & ~halted & ~illegal;
  assign accept      = instr_valid & ~bus.stall;

  always_comb begin
    illegal = 1'b1;
    case (bus.rom_q[6:0])
      7'b0110011, 7'b0010011, 7'b0100011, 7'b0000011,
      7'b1100011, 7'b1101111, 7'b1100111: illegal = 1'b0;
      7'b0110111, 7'b0010111:             illegal = (EXT_OPS == 0);
      default:                            illegal = 1'b1;
    endcase
  end

  // Reset and halt both pin the ROM address so a stray redirect cannot move it.
  always_comb begin
    sel_pc = fpc;
    if (!rst_n) begin
      sel_pc = RST_PC;
    end else if (!halted) begin
      if (bus.redirect)
        sel_pc = tgt_pc;
      else if (bus.stall && req_valid)
        sel_pc = req_pc;
    end
  end

  assign bus.rom_addr = sel_pc[ROM_AW+1:2];
  assign unused_sel   = ^sel_pc;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      fpc       <= RST_PC;
      req_pc    <= RST_PC;
      req_valid <= 1'b0;
      halt_pc_q <= '0;
      retired_q <= '0;
    end else if (state == RUN) begin
      if (bus.redirect) begin
        req_pc    <= tgt_pc;
        fpc       <= tgt_pc + PC_STEP;
        req_valid <= 1'b1;
      end else if (!bus.stall) begin
        req_pc    <= fpc;
        fpc       <= fpc + PC_STEP;
        req_valid <= 1'b1;
      end
      if (req_valid && illegal) begin
        state     <= HALT;
        halt_pc_q <= req_pc;
      end
      if (accept)
        retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.instr       = bus.rom_q;
  assign bus.instr_pc    = req_pc;
  assign bus.instr_valid = instr_valid;
  assign bus.pc_plus4    = req_pc + PC_STEP;
  assign bus.halted      = halted;
  assign bus.halt_pc     = halt_pc_q;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected fetch PCs are queued as stimulus
// is driven and compared against every accepted instruction.
module tb_fetch_unit;
  localparam int unsigned PC_W   = 11;
  localparam int unsigned ROM_AW = 8;
  localparam int unsigned CNT_W  = 32;

  logic CLOCK_50 = 1'b0;
  logic rst_n    = 1'b0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [PC_W-1:0]  exp_q[$];
  logic [CNT_W-1:0] ret_model = '0;
  logic [31:0]      rom [2**ROM_AW];

  logic [31:0]       hold_instr;
  logic [PC_W-1:0]   hold_pc;
  logic [ROM_AW-1:0] frz_addr;

  fetch_unit_if #(.PC_W(PC_W), .ROM_AW(ROM_AW), .CNT_W(CNT_W)) bus ();

  fetch_unit #(
    .PC_W(PC_W), .ROM_AW(ROM_AW), .RESET_PC(0), .EXT_OPS(0), .CNT_W(CNT_W)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) bus.rom_q <= rom[bus.rom_addr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  always @(negedge CLOCK_50) begin
    logic [PC_W-1:0] p;
    if (rst_n) begin
      chk("retired", 64'(bus.retired), 64'(ret_model));
      if (bus.instr_valid && !bus.stall) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected", 64'(exp_q.size()), 64'd1);
        end else begin
          p = exp_q.pop_front();
          chk("sb_pc", 64'(bus.instr_pc), 64'(p));
          chk("sb_instr", 64'(bus.instr), 64'(rom[p[ROM_AW+1:2]]));
          ret_model = ret_model + CNT_W'(1);
        end
      end
    end
  end

  initial begin
    logic [6:0] ops [7];
    ops = '{7'h33, 7'h13, 7'h23, 7'h03, 7'h63, 7'h6F, 7'h67};
    for (int i = 0; i < 2**ROM_AW; i++)
      rom[i] = {25'(i + 'h100), ops[i % 7]};

    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    rst_n           = 1'b0;
    repeat (2) tick();

    chk("rst_valid",    64'(bus.instr_valid), 64'd0);
    chk("rst_rom_addr", 64'(bus.rom_addr),    64'd0);
    chk("rst_retired",  64'(bus.retired),     64'd0);
    chk("rst_halted",   64'(bus.halted),      64'd0);
    chk("rst_halt_pc",  64'(bus.halt_pc),     64'd0);
    bus.redirect    = 1'b1;
    bus.redirect_pc = PC_W'('h40);
    #1;
    chk("rst_rom_addr_redir", 64'(bus.rom_addr), 64'd0);
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;

    // Sequential fetch from reset release.
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(PC_W'(4 * k));
      tick();
      chk("seq_valid", 64'(bus.instr_valid), 64'd1);
      chk("seq_pc",    64'(bus.instr_pc),    64'(4 * k));
    end
    chk("retired4", 64'(bus.retired), 64'd4);

    // Three-cycle stall at 0x10.
    bus.stall  = 1'b1;
    hold_instr = bus.instr;
    hold_pc    = bus.instr_pc;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_instr",   64'(bus.instr),       64'(hold_instr));
      chk("stall_pc",      64'(bus.instr_pc),    64'h10);
      chk("stall_valid",   64'(bus.instr_valid), 64'd1);
      chk("stall_retired", 64'(bus.retired),     64'd4);
    end
    bus.stall = 1'b0;
    exp_q.push_back(PC_W'('h14));
    tick();
    chk("stall_release_pc", 64'(bus.instr_pc), 64'h14);
    exp_q.push_back(PC_W'('h18));
    tick();

    // Zero-bubble redirect.
    bus.redirect    = 1'b1;
    bus.redirect_pc = PC_W'('h40);
    exp_q.push_back(PC_W'('h40));
    tick();
    bus.redirect = 1'b0;
    chk("redir_valid", 64'(bus.instr_valid), 64'd1);
    chk("redir_pc",    64'(bus.instr_pc),    64'h40);
    exp_q.push_back(PC_W'('h44));
    tick();
    chk("redir_next_valid", 64'(bus.instr_valid), 64'd1);
    chk("redir_next_pc",    64'(bus.instr_pc),    64'h44);
    chk("pc_plus4",         64'(bus.pc_plus4),    64'h48);

    // Redirect wins over stall; the held 0x44 is discarded, low bits masked.
    bus.stall       = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = PC_W'('h23);
    void'(exp_q.pop_front());
    exp_q.push_back(PC_W'('h20));
    tick();
    bus.stall    = 1'b0;
    bus.redirect = 1'b0;
    chk("rs_valid", 64'(bus.instr_valid), 64'd1);
    chk("rs_pc",    64'(bus.instr_pc),    64'h20);

    // PC wrap at the top of the address space.
    bus.redirect    = 1'b1;
    bus.redirect_pc = PC_W'('h7FC);
    exp_q.push_back(PC_W'('h7FC));
    tick();
    bus.redirect = 1'b0;
    chk("wrap_pc",    64'(bus.instr_pc), 64'h7FC);
    chk("wrap_plus4", 64'(bus.pc_plus4), 64'h0);
    exp_q.push_back(PC_W'(0));
    tick();
    chk("wrap_pc0",    64'(bus.instr_pc),    64'h0);
    chk("wrap_valid0", 64'(bus.instr_valid), 64'd1);
    exp_q.push_back(PC_W'(4));
    tick();
    chk("wrap_pc4", 64'(bus.instr_pc), 64'h4);

    // Asynchronous reset mid-stream.
    chk("q_pre_rst", 64'(exp_q.size()), 64'd1);
    bus.stall = 1'b1;
    rst_n     = 1'b0;
    #1;
    chk("mrst_valid",    64'(bus.instr_valid), 64'd0);
    chk("mrst_pc",       64'(bus.instr_pc),    64'd0);
    chk("mrst_retired",  64'(bus.retired),     64'd0);
    chk("mrst_halted",   64'(bus.halted),      64'd0);
    chk("mrst_rom_addr", 64'(bus.rom_addr),    64'd0);
    exp_q.delete();
    ret_model = '0;
    bus.stall = 1'b0;

    // Illegal word at 0x0C halts fetch.
    rom[3] = 32'h0000_0000;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(PC_W'(4 * k));
      tick();
      chk("h_seq_pc", 64'(bus.instr_pc), 64'(4 * k));
    end
    tick();
    chk("h_ill_valid",  64'(bus.instr_valid), 64'd0);
    chk("h_ill_pc",     64'(bus.instr_pc),    64'hC);
    chk("h_ill_halted", 64'(bus.halted),      64'd0);
    tick();
    chk("h_halted",  64'(bus.halted),      64'd1);
    chk("h_halt_pc", 64'(bus.halt_pc),     64'hC);
    chk("h_retired", 64'(bus.retired),     64'd3);
    chk("h_valid",   64'(bus.instr_valid), 64'd0);
    frz_addr        = bus.rom_addr;
    hold_pc         = bus.instr_pc;
    bus.redirect    = 1'b1;
    bus.redirect_pc = PC_W'('h40);
    for (int k = 0; k < 3; k++) begin
      bus.stall = k[0];
      #1;
      chk("h_frz_addr", 64'(bus.rom_addr), 64'(frz_addr));
      tick();
      chk("h_frz_halted",  64'(bus.halted),      64'd1);
      chk("h_frz_valid",   64'(bus.instr_valid), 64'd0);
      chk("h_frz_pc",      64'(bus.instr_pc),    64'(hold_pc));
      chk("h_frz_retired", 64'(bus.retired),     64'd3);
    end
    bus.redirect = 1'b0;
    bus.stall    = 1'b0;

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
